// File: rtl/dsram_lsu_bridge.sv
// Load/store bridge from the memory-stage request port to the byte-lane data SRAM.
// Define DSRAM_LSU_SPLIT_EN to split lane-crossing accesses into two SRAM beats.
module dsram_lsu_bridge #(
    parameter int unsigned AW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [AW+1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic          sram_csn,
    output logic          sram_wen,
    output logic [3:0]    sram_ben,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_din,
    input  logic [31:0]   sram_dout
);

`ifdef DSRAM_LSU_SPLIT_EN
    typedef enum logic [1:0] {IDLE, RESP, SPLIT} state_e;
`else
    typedef enum logic [1:0] {IDLE, RESP} state_e;
`endif

    state_e      state_q;
    logic        en_q;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        we_q;
    logic        err_q;

    logic        accept;
    logic [3:0]  mask;
    logic [7:0]  lanes;
    logic        crossing;
    logic        bad_size;
    logic        req_err;
    logic [63:0] wd2;
    logic [31:0] din_rot;
    logic [31:0] rd_word;
    logic [63:0] rd2;
    logic [31:0] rd_sh;
    logic [31:0] rd_ext;

`ifdef DSRAM_LSU_SPLIT_EN
    logic          split_q;
    logic [31:0]   cap_q;
    logic [AW-1:0] addr2_q;
    logic [3:0]    ben2_q;
    logic [31:0]   din_q;
`endif

    assign req_ready = en_q & ((state_q == IDLE) | ((state_q == RESP) & rsp_ready));
    assign accept    = req_valid & req_ready;

    always_comb begin
        case (req_size)
            2'd0:    mask = 4'b0001;
            2'd1:    mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
    end

    // Upper nibble holds the lanes that spill into the next word.
    assign lanes    = {4'b0000, mask} << req_addr[1:0];
    assign crossing = |lanes[7:4];
    assign bad_size = (req_size == 2'd3);
`ifdef DSRAM_LSU_SPLIT_EN
    assign req_err  = bad_size;
`else
    assign req_err  = bad_size | crossing;
`endif

    assign wd2     = {req_wdata, req_wdata} << {req_addr[1:0], 3'b000};
    assign din_rot = wd2[63:32];

    always_comb begin
        sram_csn  = 1'b1;
        sram_wen  = 1'b1;
        sram_ben  = 4'b0000;
        sram_addr = '0;
        sram_din  = '0;
`ifdef DSRAM_LSU_SPLIT_EN
        if (state_q == SPLIT) begin
            sram_csn  = 1'b0;
            sram_wen  = ~we_q;
            sram_ben  = we_q ? ben2_q : 4'b0000;
            sram_addr = addr2_q;
            sram_din  = din_q;
        end else
`endif
        if (accept && !req_err) begin
            sram_csn  = 1'b0;
            sram_wen  = ~req_we;
            sram_ben  = req_we ? lanes[3:0] : 4'b0000;
            sram_addr = req_addr[AW+1:2];
            sram_din  = din_rot;
        end
    end

    // Split loads: lanes at or above the offset came from the first (captured) beat.
`ifdef DSRAM_LSU_SPLIT_EN
    always_comb begin
        rd_word = sram_dout;
        if (split_q) begin
            for (int i = 0; i < 4; i++) begin
                if (i >= int'(off_q)) rd_word[8*i +: 8] = cap_q[8*i +: 8];
            end
        end
    end
`else
    assign rd_word = sram_dout;
`endif

    assign rd2   = {rd_word, rd_word} >> {off_q, 3'b000};
    assign rd_sh = rd2[31:0];

    always_comb begin
        case (size_q)
            2'd0:    rd_ext = {{24{~uns_q & rd_sh[7]}}, rd_sh[7:0]};
            2'd1:    rd_ext = {{16{~uns_q & rd_sh[15]}}, rd_sh[15:0]};
            default: rd_ext = rd_sh;
        endcase
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = rsp_valid & err_q;
    assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? rd_ext : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            off_q   <= 2'd0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
`ifdef DSRAM_LSU_SPLIT_EN
            split_q <= 1'b0;
            cap_q   <= '0;
            addr2_q <= '0;
            ben2_q  <= 4'b0000;
            din_q   <= '0;
`endif
        end else begin
            en_q <= 1'b1;
`ifdef DSRAM_LSU_SPLIT_EN
            if (state_q == SPLIT) begin
                cap_q   <= sram_dout;
                state_q <= RESP;
            end else
`endif
            if (accept) begin
                off_q   <= req_addr[1:0];
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                we_q    <= req_we;
                err_q   <= req_err;
                state_q <= RESP;
`ifdef DSRAM_LSU_SPLIT_EN
                split_q <= crossing & ~bad_size;
                addr2_q <= req_addr[AW+1:2] + AW'(1);
                ben2_q  <= lanes[7:4];
                din_q   <= din_rot;
                if (crossing && !bad_size) state_q <= SPLIT;
`endif
            end else if (state_q == RESP && rsp_ready) begin
                state_q <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_dsram_lsu_bridge.sv
// Directed bench for dsram_lsu_bridge with a behavioural registered-read SRAM.
module tb_dsram_lsu_bridge;
    localparam int unsigned AW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]    req_size;
    logic [AW+1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [31:0]   rsp_rdata;
    logic          sram_csn, sram_wen;
    logic [3:0]    sram_ben;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_din;
    logic [31:0]   sram_dout;

    logic [31:0] mem [0:(1<<AW)-1];
    int n_cmp = 0;
    int n_err = 0;

    dsram_lsu_bridge #(.AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .sram_csn(sram_csn), .sram_wen(sram_wen), .sram_ben(sram_ben),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
    );

    always #5 clk = ~clk;

    // Registered read address: dout only changes on a read access.
    always @(posedge clk) begin
        if (!sram_csn) begin
            if (!sram_wen) begin
                for (int i = 0; i < 4; i++)
                    if (sram_ben[i]) mem[sram_addr][8*i +: 8] <= sram_din[8*i +: 8];
            end else begin
                sram_dout <= mem[sram_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                         input logic [AW+1:0] addr, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        #1;
    endtask

    initial begin
        sram_dout = 32'h0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[(1<<AW)-1] = 32'h0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;

        #3;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_csn", sram_csn, 1);
        check("rst_wen", sram_wen, 1);
        check("rst_ben", sram_ben, 0);
        check("rst_addr", sram_addr, 0);
        check("rst_din", sram_din, 0);
        #9 rst_n = 1'b1;
        #1 check("ready_before_edge", req_ready, 0);
        step();
        check("ready_after_edge", req_ready, 1);

        drive(1'b1, 2'd2, 1'b0, 18'h10, 32'hDEADBEEF);
        check("sw_csn", sram_csn, 0);
        check("sw_wen", sram_wen, 0);
        check("sw_ben", sram_ben, 4'hF);
        check("sw_addr", sram_addr, 4);
        check("sw_din", sram_din, 32'hDEADBEEF);
        step();
        drive(1'b0, 2'd2, 1'b0, 18'h10, 32'h0);
        check("sw_rsp_valid", rsp_valid, 1);
        check("sw_rsp_rdata", rsp_rdata, 0);
        check("lw_ready_b2b", req_ready, 1);
        check("lw_wen", sram_wen, 1);
        check("lw_ben", sram_ben, 0);
        step();
        check("lw_rsp_valid", rsp_valid, 1);
        check("lw_rdata", rsp_rdata, 32'hDEADBEEF);
        check("lw_err", rsp_err, 0);

        drive(1'b1, 2'd0, 1'b0, 18'h13, 32'h00000080);
        check("sb_ben", sram_ben, 4'b1000);
        check("sb_din", sram_din, 32'h80000000);
        step();
        drive(1'b0, 2'd0, 1'b0, 18'h13, 32'h0);
        step();
        check("lb_signed", rsp_rdata, 32'hFFFFFF80);
        drive(1'b0, 2'd0, 1'b1, 18'h13, 32'h0);
        step();
        check("lbu", rsp_rdata, 32'h00000080);
        drive(1'b0, 2'd1, 1'b0, 18'h11, 32'h0);
        check("lh_o1_csn", sram_csn, 0);
        step();
        check("lh_o1_signed", rsp_rdata, 32'hFFFFADBE);
        drive(1'b0, 2'd1, 1'b1, 18'h12, 32'h0);
        step();
        check("lhu_o2", rsp_rdata, 32'h000080AD);

        // Backpressure: response held while a new request waits.
        drive(1'b0, 2'd2, 1'b0, 18'h10, 32'h0);
        step();
        rsp_ready = 1'b0;
        drive(1'b1, 2'd2, 1'b0, 18'h20, 32'h12345678);
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", rsp_valid, 1);
            check("bp_rdata", rsp_rdata, 32'h80ADBEEF);
            check("bp_ready", req_ready, 0);
            check("bp_csn", sram_csn, 1);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", req_ready, 1);
        check("bp_release_csn", sram_csn, 0);
        check("bp_release_addr", sram_addr, 8);
        step();
        check("bp_next_valid", rsp_valid, 1);
        check("bp_next_rdata", rsp_rdata, 0);

        drive(1'b1, 2'd2, 1'b0, 18'h0C, 32'h44332211);
        step();
        drive(1'b1, 2'd2, 1'b0, 18'h10, 32'h88776655);
        step();
        drive(1'b0, 2'd2, 1'b0, 18'h0D, 32'h0);
`ifdef DSRAM_LSU_SPLIT_EN
        check("xl_b1_csn", sram_csn, 0);
        check("xl_b1_addr", sram_addr, 3);
        step();
        req_valid = 1'b0;
        #1;
        check("xl_split_ready", req_ready, 0);
        check("xl_split_valid", rsp_valid, 0);
        check("xl_b2_csn", sram_csn, 0);
        check("xl_b2_addr", sram_addr, 4);
        step();
        check("xl_rsp_valid", rsp_valid, 1);
        check("xl_rdata", rsp_rdata, 32'h55443322);
        check("xl_err", rsp_err, 0);
`else
        check("xl_csn", sram_csn, 1);
        check("xl_ready", req_ready, 1);
        step();
        req_valid = 1'b0;
        #1;
        check("xl_rsp_valid", rsp_valid, 1);
        check("xl_err", rsp_err, 1);
        check("xl_rdata", rsp_rdata, 0);
        check("xl_csn_after", sram_csn, 1);
`endif
        step();

        drive(1'b0, 2'd3, 1'b0, 18'h10, 32'h0);
        check("ill_csn", sram_csn, 1);
        step();
        req_valid = 1'b0;
        #1;
        check("ill_err", rsp_err, 1);
        check("ill_rdata", rsp_rdata, 0);
        step();
        check("idle_valid", rsp_valid, 0);
        check("idle_rdata", rsp_rdata, 0);

`ifdef DSRAM_LSU_SPLIT_EN
        drive(1'b1, 2'd2, 1'b0, 18'h3FFFF, 32'hAABBCCDD);
        check("wrap_b1_ben", sram_ben, 4'b1000);
        check("wrap_b1_addr", sram_addr, 16'hFFFF);
        check("wrap_b1_din", sram_din, 32'hDDAABBCC);
        step();
        req_valid = 1'b0;
        #1;
        check("wrap_b2_csn", sram_csn, 0);
        check("wrap_b2_addr", sram_addr, 0);
        check("wrap_b2_ben", sram_ben, 4'b0111);
        check("wrap_b2_din", sram_din, 32'hDDAABBCC);
        step();
        check("wrap_rsp_valid", rsp_valid, 1);
        step();
        drive(1'b0, 2'd2, 1'b0, 18'h0D, 32'h0);
`else
        drive(1'b0, 2'd2, 1'b0, 18'h10, 32'h0);
`endif
        step();
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_csn", sram_csn, 1);
        check("mid_rst_ready", req_ready, 0);
        check("mid_rst_ben", sram_ben, 0);
        check("mid_rst_addr", sram_addr, 0);
        #2 rst_n = 1'b1;
        #1 check("post_rst_ready0", req_ready, 0);
        step();
        check("post_rst_ready1", req_ready, 1);
        drive(1'b0, 2'd2, 1'b0, 18'h0C, 32'h0);
        step();
        req_valid = 1'b0;
        #1;
        check("post_rst_valid", rsp_valid, 1);
        check("post_rst_rdata", rsp_rdata, 32'h44332211);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dsram_lsu_bridge.md
# dsram_lsu_bridge

Load/store bridge between the core's memory-stage request port and the byte-lane data SRAM (`dsram`). It accepts one request per cycle over a valid/ready handshake and generates the SRAM chip-select, write-enable, byte-lane enables and rotated write data. It returns load data aligned, masked and sign-/zero-extended through a valid/ready response port. It exploits the SRAM's registered read address, which holds `dout` stable while `csn` is high.

## Interface
- `AW`, 16, SRAM word-address width; the request byte address is `AW+2` bits.
- `clk` in 1, single clock; all state on rising edge.
- `rst_n` in 1, asynchronous active-low reset.
- `req_valid` in 1, request present.
- `req_ready` out 1, request accepted when `req_valid & req_ready`.
- `req_we` in 1, 1=store, 0=load.
- `req_size` in 2, 0=byte, 1=half, 2=word; 3 is illegal and returns an error response.
- `req_unsigned` in 1, zero-extend load (lbu/lhu).
- `req_addr` in AW+2, byte address.
- `req_wdata` in 32, store data, LSB-justified.
- `rsp_valid` out 1, response present.
- `rsp_ready` in 1, response consumed when `rsp_valid & rsp_ready`.
- `rsp_rdata` out 32, load result; 0 for stores, errors, and whenever `rsp_valid=0`.
- `rsp_err` out 1, access error; meaningful only with `rsp_valid`.
- `sram_csn`, `sram_wen` out 1, SRAM strobes, active low.
- `sram_ben` out 4, byte-lane write enables.
- `sram_addr` out AW, word address.
- `sram_din` out 32, SRAM write data.
- `sram_dout` in 32, SRAM read data, valid the cycle after a read access.

## Operation
- Offset `o = req_addr[1:0]`, byte count `n = 1/2/4`. The access touches lanes `o..o+n-1`. It is "crossing" if `o+n>4`.
- Non-crossing accesses, including half at o=1, take one SRAM access:
  - `sram_csn=0`; `sram_wen=~req_we`.
  - `sram_addr=req_addr[AW+1:2]`.
  - `sram_ben`: store lanes set; 0000 for loads.
  - `sram_din = req_wdata` rotated left by 8·o.
- Load result: `sram_dout` rotated right by 8·o, keep n bytes, then sign-extend from bit 8n-1 unless `req_unsigned`. The bridge registers size, unsigned and offset at accept.
- States: IDLE (no response pending), RESP (response pending), SPLIT (second beat, only with macro).
  - IDLE→RESP on accept.
  - RESP→RESP on accept in the same cycle the response is consumed.
  - RESP→IDLE on consume with no accept.
- `req_ready = en_q & (state==IDLE | (state==RESP & rsp_ready))`, giving throughput of 1 request/cycle.
- `en_q` resets to 0 and is set on the first clock edge after `rst_n` deasserts.
- SRAM strobes are combinational from the accepted request. When `sram_csn=1`: `sram_wen=1`, `ben=0000`, `addr=0`, `din=0`.
- Illegal size, and crossing accesses without the macro: no SRAM access (`csn` stays 1). The request enters RESP with `rsp_err=1` and `rdata=0`.
- Reset mid-operation: pending response and any split are abandoned; SRAM beats already written stay written.

## Timing
- Reset values:
  - `rsp_valid=0`, `rsp_err=0`, `rsp_rdata=0`.
  - `req_ready=0`.
  - `sram_csn=1`, `sram_wen=1`, `sram_ben=0`, `sram_addr=0`, `sram_din=0`.
- Single-beat request accepted in cycle N: SRAM access in N; `rsp_valid` in N+1.
- Load data is driven combinationally from `sram_dout`. It stays stable under backpressure because no new access issues while the response is held.
- `rsp_valid` and `rsp_rdata` hold until consumed.

## Configuration
- `DSRAM_LSU_SPLIT_EN` defined: crossing accesses are split into two beats.
  - Beat 1 in N: word A, lanes o..3.
  - Beat 2 in N+1 (state SPLIT, `req_ready=0`): word A+1 modulo 2^AW, lanes 0..o+n-5, same rotated `din`.
  - For loads, beat 1 data is captured at the end of N+1.
  - Response in N+2. The combined word takes lane i from beat 1 if i≥o, else from beat 2. It is then rotated, masked and extended as for single-beat loads.
- `DSRAM_LSU_SPLIT_EN` undefined: crossing accesses return `rsp_err=1`; the SPLIT state and capture register are absent.

## Test plan
- Store word 0xDEADBEEF at 0x10 (`ben=1111`), then load word 0x10 → `rsp_rdata=0xDEADBEEF`, `rsp_err=0`, `rsp_valid` one cycle after accept.
- Store byte `wdata=0x00000080` at 0x13 → `ben=1000`, `din=0x80000000`. Load byte signed 0x13 → 0xFFFFFF80; unsigned → 0x00000080.
- Load accepted with `rsp_ready=0` for 3 cycles:
  - `rsp_valid` and `rdata` stay stable, `req_ready=0`, `csn=1`.
  - On consume, a back-to-back request is accepted in the same cycle.
- Word 0x44332211 at word 3, 0x88776655 at word 4; load word at 0x0D:
  - Without macro → `rsp_err=1`, `rdata=0`, no `csn` pulse.
  - With macro → two reads of word 3 then word 4, `rdata=0x55443322`, response at N+2.
- With macro, store word 0xAABBCCDD at byte address 2^(AW+2)-1 → beat 1 at word 2^AW-1 with `ben=1000`, beat 2 at word 0 with `ben=0111`.
- Assert `rst_n` during the SPLIT cycle → all outputs go to reset values immediately; after release, `req_ready` rises after one edge and a fresh load completes normally.
